// File: rtl/writeback_select.sv
// writeback_select: registered write-back data selector for the RISC CPU.
// Picks ALU, load, link or flag data and waits for late memory data.
module writeback_select #(
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        md,
    input  logic [WIDTH-1:0]  f,
    input  logic [WIDTH-1:0]  data_out,
    input  logic              mem_valid,
    input  logic [WIDTH-1:0]  pc_link,
    input  logic              n_xor_v,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [ADDR_W-1:0] dest_in,
    output logic              stall,
    output logic [WIDTH-1:0]  bus_d,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_dest,
    output logic              timeout_err
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    localparam int CW = $clog2(MEM_TIMEOUT + 2);

    state_t            state_q, state_nx;
    logic [CW-1:0]     cnt_q, cnt_nx;
    logic [1:0]        size_q, size_nx;
    logic              sign_q, sign_nx;
    logic [ADDR_W-1:0] pend_q, pend_nx;
    logic [WIDTH-1:0]  bus_nx;
    logic              valid_nx;
    logic [ADDR_W-1:0] dest_nx;
    logic              err_nx;

    logic [1:0]        sel_size;
    logic              sel_sign;
    logic [WIDTH-1:0]  ext;
    logic              timeout_hit;

    // A fresh load uses its own size/sign; a late load uses the captured ones.
    assign sel_size = (state_q == IDLE) ? ld_size : size_q;
    assign sel_sign = (state_q == IDLE) ? ld_signed : sign_q;

    assign timeout_hit = (MEM_TIMEOUT > 0) &&
                         (cnt_q == CW'(MEM_TIMEOUT - 1));

    assign stall = (state_q == WAIT_MEM) |
                   (in_valid & (md == 2'b01) & ~mem_valid &
                    (state_q == IDLE));

    // Extract and sign/zero extend byte and halfword loads.
    always_comb begin
        ext = data_out;
        case (sel_size)
            2'b01: begin
                for (int i = 16; i < WIDTH; i++) begin
                    ext[i] = sel_sign & data_out[15];
                end
            end
            2'b10: begin
                for (int i = 8; i < WIDTH; i++) begin
                    ext[i] = sel_sign & data_out[7];
                end
            end
            default: ext = data_out;
        endcase
    end

    // Next-state and next-output logic for the IDLE/WAIT_MEM controller.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        size_nx  = size_q;
        sign_nx  = sign_q;
        pend_nx  = pend_q;
        bus_nx   = bus_d;
        dest_nx  = wb_dest;
        valid_nx = 1'b0;
        err_nx   = timeout_err;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (md)
                        2'b00: begin
                            bus_nx   = f;
                            dest_nx  = dest_in;
                            valid_nx = 1'b1;
                        end
                        2'b10: begin
                            bus_nx   = pc_link;
                            dest_nx  = dest_in;
                            valid_nx = 1'b1;
                        end
                        2'b11: begin
                            bus_nx    = '0;
                            bus_nx[0] = n_xor_v;
                            dest_nx   = dest_in;
                            valid_nx  = 1'b1;
                        end
                        default: begin
                            if (mem_valid) begin
                                bus_nx   = ext;
                                dest_nx  = dest_in;
                                valid_nx = 1'b1;
                            end else begin
                                pend_nx  = dest_in;
                                size_nx  = ld_size;
                                sign_nx  = ld_signed;
                                cnt_nx   = '0;
                                state_nx = WAIT_MEM;
                            end
                        end
                    endcase
                end
            end
            default: begin
                if (mem_valid) begin
                    bus_nx   = ext;
                    dest_nx  = pend_q;
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (timeout_hit) begin
                    bus_nx   = '0;
                    dest_nx  = pend_q;
                    valid_nx = 1'b1;
                    err_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State, capture and output registers; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            pend_q      <= '0;
            bus_d       <= '0;
            wb_valid    <= 1'b0;
            wb_dest     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_nx;
            cnt_q       <= cnt_nx;
            size_q      <= size_nx;
            sign_q      <= sign_nx;
            pend_q      <= pend_nx;
            bus_d       <= bus_nx;
            wb_valid    <= valid_nx;
            wb_dest     <= dest_nx;
            timeout_err <= err_nx;
        end
    end

endmodule
